// File: rtl/ctrl_io_dr_pkg.sv
// Shared dual-rail codeword constants, FSM state type and codeword helpers
// for the multi-channel control-IO block.
package ctrl_io_dr_pkg;

  // Codewords packed as {t, f}
  localparam logic [1:0] DR_SPACER  = 2'b00;
  localparam logic [1:0] DR_ONE     = 2'b10;
  localparam logic [1:0] DR_ZERO    = 2'b01;
  localparam logic [1:0] DR_INVALID = 2'b11;

  typedef enum logic [1:0] {
    PRECH = 2'd0,
    EVAL  = 2'd1,
    FAULT = 2'd2
  } state_t;

  function automatic logic is_invalid(input logic t, input logic f);
    return t & f;
  endfunction

endpackage

// File: rtl/ctrl_io_dr_chan.sv
// One dual-rail channel: direction mux, pad/fabric data registers and the
// per-channel invalid/spacer observations used by the fault logic.
module ctrl_io_dr_chan
  import ctrl_io_dr_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_dir,
  input  logic i_eval,
  input  logic i_fab_t,
  input  logic i_fab_f,
  input  logic i_pad_t,
  input  logic i_pad_f,
  output logic o_q_t,
  output logic o_q_f,
  output logic o_pad_t,
  output logic o_pad_f,
  output logic o_tri,
  output logic invalid_o,
  output logic spacer_o
);

  logic [1:0] r_q_p0;
  logic [1:0] r_pad_p0;
  logic       r_tri_p0;
  logic [1:0] w_src;

  // Stage p0: data loads only in EVAL; every other phase reloads the spacer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q_p0   <= DR_SPACER;
      r_pad_p0 <= DR_SPACER;
      r_tri_p0 <= 1'b1;
    end else begin
      r_tri_p0 <= ~i_dir;
      r_q_p0   <= (i_eval && !i_dir) ? {i_pad_t, i_pad_f} : DR_SPACER;
      r_pad_p0 <= (i_eval &&  i_dir) ? {i_fab_t, i_fab_f} : DR_SPACER;
    end
  end

  assign w_src     = i_dir ? {i_fab_t, i_fab_f} : {i_pad_t, i_pad_f};
  assign invalid_o = is_invalid(w_src[1], w_src[0]);
  // The active data register is the one fed by this channel's source
  assign spacer_o  = ((i_dir ? r_pad_p0 : r_q_p0) == DR_SPACER);

  assign o_q_t   = r_q_p0[1];
  assign o_q_f   = r_q_p0[0];
  assign o_pad_t = r_pad_p0[1];
  assign o_pad_f = r_pad_p0[0];
  assign o_tri   = r_tri_p0;

endmodule

// File: rtl/ctrl_io_dr_multi.sv
// Multi-channel dual-rail control-IO: phase FSM, fault event detection,
// saturating fault counter, F_ctrl and the sticky safe state.
module ctrl_io_dr_multi
  import ctrl_io_dr_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int FCNT_W  = 4,
  parameter int FTHRESH = 3
) (
  input  logic              UserCLK,
  input  logic              rst,
  input  logic [NCH-1:0]    I_t,
  input  logic [NCH-1:0]    I_f,
  output logic [NCH-1:0]    Q_t,
  output logic [NCH-1:0]    Q_f,
  input  logic [NCH-1:0]    O_top_t,
  input  logic [NCH-1:0]    O_top_f,
  output logic [NCH-1:0]    I_top_t,
  output logic [NCH-1:0]    I_top_f,
  output logic [NCH-1:0]    T_top,
  input  logic              prech,
  input  logic              DR_fault,
  output logic              F_ctrl,
  output logic [FCNT_W-1:0] fault_cnt,
  input  logic [NCH:0]      ConfigBits
);

  localparam logic [FCNT_W-1:0] CNT_MAX = '1;
  localparam logic [FCNT_W-1:0] THRESH  = FCNT_W'(FTHRESH);

  function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + FCNT_W'(1);
  endfunction

  state_t            r_state_p0, w_state_nxt;
  logic [FCNT_W-1:0] r_cnt_p0;
  logic              r_fctrl_p0;
  logic [FCNT_W-1:0] w_cnt_inc;
  logic              w_eval, w_fault, w_sticky, w_event;
  logic [NCH-1:0]    w_dir, w_inv, w_spc;
  logic [NCH-1:0]    w_q_t, w_q_f, w_pad_t, w_pad_f, w_tri;

  assign w_dir    = ConfigBits[NCH-1:0];
  assign w_sticky = ConfigBits[NCH];
  assign w_eval   = (r_state_p0 == EVAL);
  assign w_fault  = (r_state_p0 == FAULT);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    ctrl_io_dr_chan u_chan (
      .i_clk     (UserCLK),
      .i_rst     (rst),
      .i_dir     (w_dir[g]),
      .i_eval    (w_eval),
      .i_fab_t   (I_t[g]),
      .i_fab_f   (I_f[g]),
      .i_pad_t   (O_top_t[g]),
      .i_pad_f   (O_top_f[g]),
      .o_q_t     (w_q_t[g]),
      .o_q_f     (w_q_f[g]),
      .o_pad_t   (w_pad_t[g]),
      .o_pad_f   (w_pad_f[g]),
      .o_tri     (w_tri[g]),
      .invalid_o (w_inv[g]),
      .spacer_o  (w_spc[g])
    );
  end

  // Any mix of causes across any channels collapses to a single event
  assign w_event   = (w_eval && |w_inv)
                   | (w_eval && prech && |w_spc)
                   | (DR_fault && !w_fault);
  assign w_cnt_inc = sat_inc(r_cnt_p0);

  always_comb begin
    w_state_nxt = r_state_p0;
    case (r_state_p0)
      PRECH:   if (!prech) w_state_nxt = EVAL;
      EVAL:    if (prech)  w_state_nxt = PRECH;
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = PRECH;
    endcase
    if (w_event && w_sticky && (w_cnt_inc >= THRESH)) w_state_nxt = FAULT;
  end

  // Stage p0: control state, counter and fault flag
  always_ff @(posedge UserCLK) begin
    if (rst) begin
      r_state_p0 <= PRECH;
      r_cnt_p0   <= '0;
      r_fctrl_p0 <= 1'b0;
    end else begin
      r_state_p0 <= w_state_nxt;
      if (w_event) r_cnt_p0 <= w_cnt_inc;
      r_fctrl_p0 <= w_event | (w_state_nxt == FAULT);
    end
  end

  // The safe state overrides whatever the channel registers last captured
  assign Q_t       = w_q_t   & {NCH{~w_fault}};
  assign Q_f       = w_q_f   & {NCH{~w_fault}};
  assign I_top_t   = w_pad_t & {NCH{~w_fault}};
  assign I_top_f   = w_pad_f & {NCH{~w_fault}};
  assign T_top     = w_tri   | {NCH{w_fault}};
  assign F_ctrl    = r_fctrl_p0;
  assign fault_cnt = r_cnt_p0;

endmodule

// File: doc/ctrl_io_dr_multi.md
# ctrl_io_dr_multi

Parametrised, multi-channel successor to the single-channel dual-rail bidirectional IO BEL in the SAUBER fabric's control-IO tiles. Registers NCH dual-rail channels in both directions (fabric↔pad), enforces the precharge/evaluate phase discipline, and detects invalid and incomplete codewords as well as an external fault flag. Faults are counted, and a configurable threshold drives the tile into a sticky safe state. It sits between the tile switch matrix and the top-level pad ring, with static configuration taken from the tile ConfigMem.

## Interface
Parameters:
- NCH, 4: number of dual-rail channels (1..16).
- FCNT_W, 4: fault counter width.
- FTHRESH, 3: fault count that triggers the sticky FAULT state (1..2^FCNT_W-1).

Ports:
- UserCLK  in  1  fabric user clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- I_t, I_f  in  NCH each  fabric-side dual-rail data toward the pad.
- Q_t, Q_f  out  NCH each  registered pad data toward the fabric.
- O_top_t, O_top_f  in  NCH each  pad-side dual-rail data.
- I_top_t, I_top_f  out  NCH each  registered data to the pad.
- T_top  out  NCH  pad tristate; 1 = input/high-Z.
- prech  in  1  phase input; 1 = precharge, 0 = evaluate.
- DR_fault  in  1  external dual-rail fault flag.
- F_ctrl  out  1  fault indication.
- fault_cnt  out  FCNT_W  saturating fault-event count.
- ConfigBits  in  NCH+1  bits [NCH-1:0] set channel direction (1 = output to pad); bit [NCH] is sticky_en.

## Operation
- Codewords: (t,f) = (1,0) is logic 1, (0,1) is logic 0, (0,0) is the spacer, and (1,1) is invalid.
- State machine: PRECH, EVAL, FAULT. Reset enters PRECH.
  - PRECH → EVAL when prech is sampled 0.
  - EVAL → PRECH when prech is sampled 1.
  - Any state → FAULT when sticky_en=1 and the post-increment count is ≥ FTHRESH.
  - FAULT is left only via rst.
- PRECH: all Q and I_top registers load the spacer. T_top follows the direction config.
- EVAL: for an input channel (dir=0), Q registers O_top every cycle and I_top holds the spacer. For an output channel (dir=1), I_top registers I every cycle and Q holds the spacer.
- Fault event, at most one per cycle; any combination of the following, in any number of channels, counts as one event:
  - (a) an invalid codeword sampled in EVAL on the active source of any channel (O_top for inputs, I for outputs);
  - (b) incomplete evaluation: on the EVAL→PRECH edge, any channel's data register still holds the spacer;
  - (c) DR_fault=1 in any state except FAULT.
- fault_cnt increments by 1 per event and saturates at 2^FCNT_W−1.
- F_ctrl:
  - sticky_en=0: a one-cycle pulse in the cycle after each event; the FSM never enters FAULT.
  - sticky_en=1: F_ctrl=1 continuously in FAULT.
- FAULT: all Q and I_top outputs are the spacer and all T_top=1, regardless of inputs or config. fault_cnt is frozen.
- ConfigBits are treated as static. A change takes effect at the next cycle boundary, with no other side effects.

## Timing
- Reset values: Q_t=Q_f=I_top_t=I_top_f=0, T_top all 1, F_ctrl=0, fault_cnt=0, state PRECH.
- Data latency: 1 cycle from O_top to Q and from I to I_top.
- Phase: the first EVAL register load happens in the cycle after prech is sampled 0. The first spacer load happens in the cycle after prech is sampled 1.
- Counter update, F_ctrl, and FAULT entry all take effect 1 cycle after the event is sampled.
- rst dominates everything, including a fault event in the same cycle.
- With sticky_en=0, back-to-back events produce F_ctrl high on consecutive cycles.
- Incomplete-eval check (b) uses register contents before the edge's spacer load.

## Structure
- Package ctrl_io_dr_pkg:
  - codeword constants DR_SPACER, DR_ONE, DR_ZERO, DR_INVALID;
  - state enum {PRECH, EVAL, FAULT};
  - a helper function is_invalid.
- Sub-module ctrl_io_dr_chan, instantiated NCH times by generate. It holds per-channel registers and the direction mux, and reports invalid_o and spacer_o.
- The top level holds the FSM, the event OR-reduction, the counter, and F_ctrl.

## Test plan
- NCH=4, dir=4'b0011, prech toggling 2 cycles low / 2 high, O_top = valid 1s → Q ch2/ch3 = (1,0) one cycle after each EVAL sample, spacer in PRECH; Q ch0/ch1 = spacer; T_top = 4'b1100.
- Invalid (1,1) on O_top ch2 and ch3 in the same EVAL cycle → fault_cnt increments by exactly 1; with sticky_en=0, F_ctrl pulses for 1 cycle.
- sticky_en=1, FTHRESH=3, three DR_fault pulses → FAULT on the cycle after the third pulse; F_ctrl=1; T_top=4'hF; all outputs spacer; further faults leave fault_cnt=3.
- Output channel with I held at spacer through an entire EVAL window, then prech rises → incomplete-eval event; fault_cnt +1.
- FCNT_W=2, sticky_en=0, five events → fault_cnt saturates at 3.
- rst asserted in FAULT and coinciding with DR_fault → next cycle all reset values; state PRECH; fault_cnt=0.
